// File: rtl/counter_game_ctrl.sv
// counter_game_ctrl: referee that sequences the multimode counter and tallies its winner/loser pulses
module counter_game_ctrl #(
  parameter int N         = 4,
  parameter int SCORE_W   = 4,
  parameter int WIN_LIMIT = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode_in,
  input  logic               mode_wr,
  input  logic [N-1:0]       seed_in,
  input  logic               seed_valid,
  input  logic               winner_in,
  input  logic               loser_in,
  output logic               ctr_rst,
  output logic               ctr_init,
  output logic [N-1:0]       ctr_initial_val,
  output logic [1:0]         ctr_control,
  output logic [SCORE_W-1:0] win_count,
  output logic [SCORE_W-1:0] loss_count,
  output logic               game_over,
  output logic               winner_side,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, OVER} state_t;
  localparam logic [SCORE_W-1:0] LIMIT = SCORE_W'(WIN_LIMIT);
  state_t state_q, state_d;
  logic [N-1:0] iv_q, iv_d;
  logic [1:0] ctl_q, ctl_d;
  logic [SCORE_W-1:0] win_q, win_d, loss_q, loss_d, win_inc, loss_inc;
  logic side_q, side_d, hit_w, hit_l;
  logic ctr_rst_q, ctr_init_q, game_over_q, busy_q;
  always_comb begin
    win_inc  = win_q + SCORE_W'(winner_in && win_q != LIMIT);
    loss_inc = loss_q + SCORE_W'(loser_in && loss_q != LIMIT);
    hit_w    = win_inc == LIMIT;
    hit_l    = loss_inc == LIMIT;
    state_d  = state_q;
    iv_d     = iv_q;
    ctl_d    = ctl_q;
    win_d    = win_q;
    loss_d   = loss_q;
    side_d   = side_q;
    // LOAD always lasts exactly one cycle, so start is only honoured elsewhere
    if (start && state_q != LOAD) begin
      state_d = LOAD;
      iv_d    = seed_in;
      ctl_d   = mode_in;
      win_d   = '0;
      loss_d  = '0;
      side_d  = 1'b0;
    end else if (state_q == LOAD) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      win_d  = win_inc;
      loss_d = loss_inc;
      if (hit_w || hit_l) begin
        state_d = OVER;
        side_d  = hit_w;
      end else begin
        if (seed_valid) begin
          state_d = LOAD;
          iv_d    = seed_in;
        end
        if (mode_wr) ctl_d = mode_in;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      iv_q        <= '0;
      ctl_q       <= '0;
      win_q       <= '0;
      loss_q      <= '0;
      side_q      <= 1'b0;
      ctr_rst_q   <= 1'b1;
      ctr_init_q  <= 1'b0;
      game_over_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      iv_q        <= iv_d;
      ctl_q       <= ctl_d;
      win_q       <= win_d;
      loss_q      <= loss_d;
      side_q      <= side_d;
      ctr_rst_q   <= state_d != RUN;
      ctr_init_q  <= state_d == LOAD;
      game_over_q <= state_d == OVER;
      busy_q      <= state_d == LOAD || state_d == RUN;
    end
  end
  assign ctr_rst         = ctr_rst_q;
  assign ctr_init        = ctr_init_q;
  assign ctr_initial_val = iv_q;
  assign ctr_control     = ctl_q;
  assign win_count       = win_q;
  assign loss_count      = loss_q;
  assign game_over       = game_over_q;
  assign winner_side     = side_q;
  assign busy            = busy_q;
endmodule

// File: tb/tb_counter_game_ctrl.sv
// tb_counter_game_ctrl: directed scenarios plus randomized run against a game-rules model, limits 3 and 15
module tb_counter_game_ctrl;
  logic clk = 0, rst, start, mode_wr, seed_valid, winner_in, loser_in;
  logic [1:0] mode_in;
  logic [3:0] seed_in;
  logic cr[2], ci[2], go[2], ws[2], bz[2];
  logic [3:0] iv[2], wc[2], lc[2];
  logic [1:0] ct[2];
  int tests = 0, fails = 0;
  // phase: 0 idle, 1 loading, 2 playing, 3 finished
  typedef struct {int phase; int iv; int ctl; int w; int l; int side;} m_t;
  m_t m[2];
  int lim[2] = '{3, 15};

  always #5 clk = ~clk;

  counter_game_ctrl #(.N(4), .SCORE_W(4), .WIN_LIMIT(3)) dut_a (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .mode_wr(mode_wr),
    .seed_in(seed_in), .seed_valid(seed_valid), .winner_in(winner_in), .loser_in(loser_in),
    .ctr_rst(cr[0]), .ctr_init(ci[0]), .ctr_initial_val(iv[0]), .ctr_control(ct[0]),
    .win_count(wc[0]), .loss_count(lc[0]), .game_over(go[0]), .winner_side(ws[0]), .busy(bz[0]));
  counter_game_ctrl #(.N(4), .SCORE_W(4), .WIN_LIMIT(15)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .mode_wr(mode_wr),
    .seed_in(seed_in), .seed_valid(seed_valid), .winner_in(winner_in), .loser_in(loser_in),
    .ctr_rst(cr[1]), .ctr_init(ci[1]), .ctr_initial_val(iv[1]), .ctr_control(ct[1]),
    .win_count(wc[1]), .loss_count(lc[1]), .game_over(go[1]), .winner_side(ws[1]), .busy(bz[1]));

  function automatic logic [18:0] obs(int k);
    return {cr[k], ci[k], iv[k], ct[k], wc[k], lc[k], go[k], ws[k], bz[k]};
  endfunction

  function automatic logic [18:0] expect_of(m_t s);
    return {s.phase != 2, s.phase == 1, 4'(s.iv), 2'(s.ctl), 4'(s.w), 4'(s.l),
            s.phase == 3, 1'(s.side), s.phase == 1 || s.phase == 2};
  endfunction

  function automatic m_t model_step(m_t s, int limit);
    m_t n = s;
    if (rst) return '{0, 0, 0, 0, 0, 0};
    if (start && s.phase != 1) return '{1, int'(seed_in), int'(mode_in), 0, 0, 0};
    if (s.phase == 1) n.phase = 2;
    else if (s.phase == 2) begin
      n.w = s.w + int'(winner_in);
      n.l = s.l + int'(loser_in);
      if (n.w == limit || n.l == limit) begin
        n.phase = 3;
        n.side = int'(n.w == limit);
      end else begin
        if (seed_valid) begin n.phase = 1; n.iv = int'(seed_in); end
        if (mode_wr) n.ctl = int'(mode_in);
      end
    end
    return n;
  endfunction

  task automatic drive(logic st, logic [3:0] sd, logic [1:0] md, logic sv, logic mw, logic wi, logic li);
    start = st; seed_in = sd; mode_in = md; seed_valid = sv; mode_wr = mw; winner_in = wi; loser_in = li;
  endtask

  task automatic tick();
    @(posedge clk);
    for (int k = 0; k < 2; k++) m[k] = model_step(m[k], lim[k]);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; drive(1, 4'hf, 2'd3, 1, 1, 1, 1); tick(); rst = 0;
    for (int k = 0; k < 2; k++) begin
      tests++;
      if (obs(k) !== 19'h40000) begin
        fails++; $display("FAIL reset dut%0d: got %h want %h", k, obs(k), 19'h40000);
      end
    end
  endtask

  task automatic test_load();
    drive(1, 4'd5, 2'd2, 0, 0, 0, 0); tick();
    tests++;
    if ({ci[0], cr[0], iv[0], ct[0], bz[0]} !== {1'b1, 1'b1, 4'd5, 2'd2, 1'b1}) begin
      fails++; $display("FAIL load: got init=%b rst=%b iv=%0d ctl=%0d busy=%b", ci[0], cr[0], iv[0], ct[0], bz[0]);
    end
    drive(0, 4'd0, 2'd0, 0, 0, 0, 0); tick();
    tests++;
    if ({ci[0], cr[0], bz[0]} !== 3'b001) begin
      fails++; $display("FAIL run_entry: got init=%b rst=%b busy=%b want 0 0 1", ci[0], cr[0], bz[0]);
    end
  endtask

  task automatic test_win_limit();
    for (int i = 1; i <= 3; i++) begin
      drive(0, 0, 0, 0, 0, 1, 0); tick();
      tests++;
      if (wc[0] !== 4'(i) || go[0] !== (i == 3)) begin
        fails++; $display("FAIL win_tally%0d: got win=%0d over=%b want %0d %b", i, wc[0], go[0], i, i == 3);
      end
    end
    tests++;
    if ({ws[0], cr[0], bz[0]} !== 3'b110) begin
      fails++; $display("FAIL win_over: got side=%b rst=%b busy=%b want 1 1 0", ws[0], cr[0], bz[0]);
    end
  endtask

  task automatic test_over_ignore();
    drive(0, 4'd7, 2'd3, 1, 1, 1, 1); tick(); tick();
    tests++;
    if ({go[0], ws[0], wc[0], lc[0], ct[0], iv[0], ci[0]} !== {1'b1, 1'b1, 4'd3, 4'd0, 2'd2, 4'd5, 1'b0}) begin
      fails++; $display("FAIL over_hold: got over=%b side=%b w=%0d l=%0d ctl=%0d iv=%0d", go[0], ws[0], wc[0], lc[0], ct[0], iv[0]);
    end
  endtask

  task automatic test_restart();
    drive(1, 4'd0, 2'd1, 0, 0, 0, 0); tick();
    tests++;
    if ({wc[0], lc[0], go[0], ws[0], ct[0], ci[0]} !== {4'd0, 4'd0, 1'b0, 1'b0, 2'd1, 1'b1}) begin
      fails++; $display("FAIL restart: got w=%0d l=%0d over=%b side=%b ctl=%0d init=%b", wc[0], lc[0], go[0], ws[0], ct[0], ci[0]);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();
  endtask

  task automatic test_both_hit();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 1, 1); tick(); end
    tests++;
    if ({wc[0], lc[0], go[0], ws[0]} !== {4'd3, 4'd3, 1'b1, 1'b1}) begin
      fails++; $display("FAIL both_hit: got w=%0d l=%0d over=%b side=%b want 3 3 1 1", wc[0], lc[0], go[0], ws[0]);
    end
  endtask

  task automatic test_seed_reload();
    rst = 1; tick(); rst = 0;
    drive(1, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 1, 0); tick(); tick();
    drive(0, 4'd9, 2'd3, 1, 1, 1, 0); tick();
    tests++;
    if ({ci[1], cr[1], iv[1], wc[1], ct[1]} !== {1'b1, 1'b1, 4'd9, 4'd3, 2'd3}) begin
      fails++; $display("FAIL seed_reload: got init=%b rst=%b iv=%0d w=%0d ctl=%0d", ci[1], cr[1], iv[1], wc[1], ct[1]);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    tests++;
    if ({ci[1], cr[1], bz[1], wc[1]} !== {1'b0, 1'b0, 1'b1, 4'd3}) begin
      fails++; $display("FAIL reload_run: got init=%b rst=%b busy=%b w=%0d", ci[1], cr[1], bz[1], wc[1]);
    end
  endtask

  task automatic test_rst_mid();
    drive(0, 0, 0, 0, 0, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    tests++;
    if (wc[1] !== 4'd4 || lc[1] !== 4'd1) begin
      fails++; $display("FAIL pre_rst: got w=%0d l=%0d want 4 1", wc[1], lc[1]);
    end
    rst = 1; drive(1, 4'd6, 2'd1, 1, 1, 1, 1); tick(); rst = 0;
    tests++;
    if (obs(1) !== 19'h40000) begin
      fails++; $display("FAIL rst_mid: got %h want %h", obs(1), 19'h40000);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(63) == 0);
      drive($urandom_range(15) == 0, 4'($urandom), 2'($urandom), $urandom_range(7) == 0,
            $urandom_range(3) == 0, $urandom_range(2) == 0, $urandom_range(2) == 0);
      for (int k = 0; k < 2; k++)
        if (m[k].phase == 2 && (m[k].w + int'(winner_in) == lim[k] || m[k].l + int'(loser_in) == lim[k]))
          mode_wr = 0;
      tick();
      for (int k = 0; k < 2; k++) begin
        tests++;
        if (obs(k) !== expect_of(m[k])) begin
          fails++; $display("FAIL random c%0d dut%0d: got %h want %h", c, k, obs(k), expect_of(m[k]));
        end
      end
    end
    rst = 0;
  endtask

  initial begin
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    m[0] = '{0, 0, 0, 0, 0, 0};
    m[1] = '{0, 0, 0, 0, 0, 0};
    test_reset();
    test_load();
    test_win_limit();
    test_over_ignore();
    test_restart();
    test_both_hit();
    test_seed_reload();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
